// File: rtl/packet_switch_avmm_window_router_if.sv
// Upstream AVMM agent port plus the per-channel downstream bundle
// of the debug window router.
interface packet_switch_avmm_window_router_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]        s_address;
  logic                         s_read;
  logic                         s_write;
  logic [DATA_WIDTH-1:0]        s_writedata;
  logic [BE_W-1:0]              s_byteenable;
  logic                         s_waitrequest;
  logic [DATA_WIDTH-1:0]        s_readdata;
  logic                         s_readdatavalid;

  logic [NUM_CH*ADDR_WIDTH-1:0] m_address;
  logic [NUM_CH-1:0]            m_read;
  logic [NUM_CH-1:0]            m_write;
  logic [NUM_CH*DATA_WIDTH-1:0] m_writedata;
  logic [NUM_CH*BE_W-1:0]       m_byteenable;
  logic [NUM_CH-1:0]            m_waitrequest;
  logic [NUM_CH*DATA_WIDTH-1:0] m_readdata;
  logic [NUM_CH-1:0]            m_readdatavalid;

  modport slave (
    input  s_address, s_read, s_write,
    input  s_writedata, s_byteenable,
    output s_waitrequest, s_readdata,
    output s_readdatavalid,
    output m_address, m_read, m_write,
    output m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata,
    input  m_readdatavalid
  );

  modport master (
    output s_address, s_read, s_write,
    output s_writedata, s_byteenable,
    input  s_waitrequest, s_readdata,
    input  s_readdatavalid,
    input  m_address, m_read, m_write,
    input  m_writedata, m_byteenable,
    output m_waitrequest, m_readdata,
    output m_readdatavalid
  );
endinterface

// File: rtl/packet_switch_avmm_window_router.sv
// Routes one upstream AVMM agent to NUM_CH address windows with
// unmapped/timeout error responses and saturating error counters.
module packet_switch_avmm_window_router #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0] WIN_BASE =
    {16'h8238, 16'h8218},
  parameter logic [NUM_CH*ADDR_WIDTH-1:0] WIN_LAST =
    {16'h8254, 16'h8234},
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  packet_switch_avmm_window_router_if.slave bus,
  output logic [15:0] err_unmapped_cnt,
  output logic [15:0] err_timeout_cnt,
  output logic        busy
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RD, ACK, RDV
  } state_t;

  state_t state, state_n;

  logic [NUM_CH*ADDR_WIDTH-1:0] m_addr_q;
  logic [NUM_CH*DATA_WIDTH-1:0] m_wd_q;
  logic [NUM_CH*BE_W-1:0]       m_be_q;
  logic [NUM_CH-1:0]            m_rd_q;
  logic [NUM_CH-1:0]            m_wr_q;
  logic                         s_wait_q;
  logic                         s_rdv_q;
  logic [DATA_WIDTH-1:0]        s_rd_q;
  logic [DATA_WIDTH-1:0]        cap_q;
  logic                         is_wr;
  logic                         err_q;
  logic [CH_W-1:0]              sel;
  logic [TW-1:0]                tmo_cnt;

  logic                  cmd;
  logic                  hit;
  logic [CH_W-1:0]       hit_idx;
  logic [ADDR_WIDTH-1:0] rebased;
  logic                  sel_wait;
  logic                  sel_rdv;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  tmo_end;

  assign cmd      = bus.s_read | bus.s_write;
  assign sel_wait = bus.m_waitrequest[sel];
  assign sel_rdv  = bus.m_readdatavalid[sel];
  assign sel_data = bus.m_readdata[sel*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_end  = (state == ISSUE || state == WAIT_RD) &&
                    (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    rebased = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.s_address >= WIN_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          bus.s_address <= WIN_LAST[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = CH_W'(i);
        rebased = bus.s_address -
                  WIN_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd) state_n = hit ? ISSUE : ACK;
      ISSUE: begin
        if (tmo_end)        state_n = ACK;
        else if (!sel_wait) state_n = is_wr ? ACK : WAIT_RD;
      end
      WAIT_RD: if (tmo_end || sel_rdv) state_n = ACK;
      ACK:     state_n = is_wr ? IDLE : RDV;
      RDV:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr_q         <= '0;
      m_wd_q           <= '0;
      m_be_q           <= '0;
      m_rd_q           <= '0;
      m_wr_q           <= '0;
      s_wait_q         <= 1'b1;
      s_rdv_q          <= 1'b0;
      s_rd_q           <= '0;
      cap_q            <= '0;
      is_wr            <= 1'b0;
      err_q            <= 1'b0;
      sel              <= '0;
      tmo_cnt          <= '0;
      err_unmapped_cnt <= '0;
      err_timeout_cnt  <= '0;
      busy             <= 1'b0;
    end else begin
      s_wait_q <= (state_n != ACK);
      s_rdv_q  <= (state_n == RDV);
      busy     <= (state_n != IDLE);
      if (state_n == RDV)
        s_rd_q <= err_q ? ERR_DATA : cap_q;
      unique case (state)
        IDLE: if (cmd) begin
          is_wr   <= bus.s_write;
          sel     <= hit_idx;
          err_q   <= !hit;
          tmo_cnt <= '0;
          if (hit) begin
            m_addr_q[hit_idx*ADDR_WIDTH +: ADDR_WIDTH] <= rebased;
            m_wd_q[hit_idx*DATA_WIDTH +: DATA_WIDTH] <=
              bus.s_writedata;
            m_be_q[hit_idx*BE_W +: BE_W] <= bus.s_byteenable;
            if (bus.s_write) m_wr_q[hit_idx] <= 1'b1;
            else             m_rd_q[hit_idx] <= 1'b1;
          end else if (err_unmapped_cnt != 16'hFFFF) begin
            err_unmapped_cnt <= err_unmapped_cnt + 16'd1;
          end
        end
        ISSUE, WAIT_RD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Timeout wins over a completion in the same cycle.
          if (tmo_end) begin
            m_rd_q <= '0;
            m_wr_q <= '0;
            err_q  <= 1'b1;
            if (err_timeout_cnt != 16'hFFFF)
              err_timeout_cnt <= err_timeout_cnt + 16'd1;
          end else if (state == ISSUE && !sel_wait) begin
            m_rd_q <= '0;
            m_wr_q <= '0;
          end else if (state == WAIT_RD && sel_rdv) begin
            cap_q <= sel_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_waitrequest   = s_wait_q;
  assign bus.s_readdatavalid = s_rdv_q;
  assign bus.s_readdata      = s_rd_q;
  assign bus.m_address       = m_addr_q;
  assign bus.m_read          = m_rd_q;
  assign bus.m_write         = m_wr_q;
  assign bus.m_writedata     = m_wd_q;
  assign bus.m_byteenable    = m_be_q;
endmodule

// File: tb/tb_packet_switch_avmm_window_router.sv
// Directed bench for the AVMM window router: routing, waits,
// unmapped and timeout errors, window boundaries, mid-flight reset.
module tb_packet_switch_avmm_window_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_unmapped_cnt;
  logic [15:0] err_timeout_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  packet_switch_avmm_window_router_if #(
    .NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)
  ) bus ();

  packet_switch_avmm_window_router #(
    .NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .err_unmapped_cnt (err_unmapped_cnt),
    .err_timeout_cnt  (err_timeout_cnt),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // observations of the last transaction
  int          st_str;
  int          str_c [2];
  int          st_ch;
  logic [15:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_wrs;
  int          ack_n, ack_k, rdv_n, rdv_k;
  logic [31:0] rdv_data;

  logic [15:0] b_addr [7] = '{16'h8218, 16'h8234, 16'h8238,
                              16'h8254, 16'h8217, 16'h8235,
                              16'h8255};
  int          b_ch   [7] = '{0, 0, 1, 1, -1, -1, -1};
  logic [15:0] b_off  [7] = '{16'h0000, 16'h001C, 16'h0000,
                              16'h001C, 16'h0000, 16'h0000,
                              16'h0000};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one upstream command and play a downstream slave that
  // holds waitrequest for ws strobe cycles and returns read data
  // rdly cycles after accepting.
  task automatic xact(input bit wr, input logic [15:0] addr,
                      input logic [31:0] wdata, input int ws,
                      input int rdly, input logic [31:0] rdata);
    bit acc, done_cmd, strobe;
    int acc_k, post, ch;
    st_str = 0; str_c[0] = 0; str_c[1] = 0; st_ch = -1;
    st_addr = '0; st_wdata = '0; st_be = '0; st_wrs = 1'b0;
    ack_n = 0; ack_k = -1; rdv_n = 0; rdv_k = -1;
    rdv_data = '0; acc = 1'b0; acc_k = 0;
    done_cmd = 1'b0; post = 0;
    bus.s_address    = addr;
    bus.s_writedata  = wdata;
    bus.s_byteenable = 4'hF;
    bus.s_write      = wr;
    bus.s_read       = !wr;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_cmd) begin
        bus.s_read  = 1'b0;
        bus.s_write = 1'b0;
      end
      strobe = |bus.m_read || |bus.m_write;
      if (bus.m_read[0] || bus.m_write[0]) str_c[0]++;
      if (bus.m_read[1] || bus.m_write[1]) str_c[1]++;
      if (strobe) begin
        st_str++;
        ch = (bus.m_read[1] || bus.m_write[1]) ? 1 : 0;
        st_ch    = ch;
        st_addr  = bus.m_address[ch*16 +: 16];
        st_wdata = bus.m_writedata[ch*32 +: 32];
        st_be    = bus.m_byteenable[ch*4 +: 4];
        st_wrs   = bus.m_write[ch];
      end
      if (!bus.s_waitrequest) begin
        ack_n++; ack_k = k; done_cmd = 1'b1;
      end
      if (bus.s_readdatavalid) begin
        rdv_n++; rdv_k = k; rdv_data = bus.s_readdata;
      end
      bus.m_readdatavalid = '0;
      if (strobe) begin
        bus.m_waitrequest = (st_str <= ws) ? 2'b11 : 2'b00;
        if (st_str > ws && !acc) begin
          acc = 1'b1; acc_k = k;
        end
      end else begin
        bus.m_waitrequest = 2'b00;
      end
      if (acc && !wr && k == acc_k + rdly) begin
        bus.m_readdatavalid = (st_ch == 1) ? 2'b10 : 2'b01;
        bus.m_readdata = (st_ch == 1) ?
          {rdata, 32'h0BAD0BAD} : {32'h0BAD0BAD, rdata};
      end
      if (ack_n > 0 && (wr || rdv_n > 0)) post++;
      if (post >= 3) break;
    end
    bus.m_readdatavalid = '0;
    bus.m_waitrequest   = '0;
    chk("xact_done", 64'(post >= 3), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    bus.s_address = '0; bus.s_read = 1'b0; bus.s_write = 1'b0;
    bus.s_writedata = '0; bus.s_byteenable = '0;
    bus.m_waitrequest = '0; bus.m_readdata = '0;
    bus.m_readdatavalid = '0;
    repeat (3) @(negedge clk);
    chk("rst_wait", bus.s_waitrequest, 1);
    chk("rst_rdv", bus.s_readdatavalid, 0);
    chk("rst_rdata", bus.s_readdata, 0);
    chk("rst_strobes", {bus.m_read, bus.m_write}, 0);
    chk("rst_maddr", bus.m_address, 0);
    chk("rst_cnts", {err_unmapped_cnt, err_timeout_cnt}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait write to channel 0
    xact(1'b1, 16'h8220, 32'h0000A5A5, 0, 0, 32'h0);
    chk("w0_wrs", st_wrs, 1);
    chk("w0_ch", st_ch, 0);
    chk("w0_addr", st_addr, 16'h0008);
    chk("w0_data", st_wdata, 32'h0000A5A5);
    chk("w0_be", st_be, 4'hF);
    chk("w0_pulse", str_c[0], 1);
    chk("w0_ch1_quiet", str_c[1], 0);
    chk("w0_ack_n", ack_n, 1);
    chk("w0_ack_lat", ack_k, 1);

    // read on channel 1 with 3 wait cycles, data 2 cycles later
    xact(1'b0, 16'h8240, 32'h0, 3, 2, 32'h00001234);
    chk("r1_ch", st_ch, 1);
    chk("r1_addr", st_addr, 16'h0008);
    chk("r1_strobe_len", str_c[1], 4);
    chk("r1_ch0_quiet", str_c[0], 0);
    chk("r1_rdv_n", rdv_n, 1);
    chk("r1_data", rdv_data, 32'h00001234);
    chk("r1_rdv_after_ack", rdv_k - ack_k, 1);
    chk("r1_cnts", {err_unmapped_cnt, err_timeout_cnt}, 0);

    // unmapped read and write
    xact(1'b0, 16'h9000, 32'h0, 0, 1, 32'h0);
    chk("um_rd_strobe", st_str, 0);
    chk("um_rd_data", rdv_data, 32'hDEADBEEF);
    chk("um_rd_lat", rdv_k - ack_k, 1);
    chk("um_rd_cnt", err_unmapped_cnt, 1);
    xact(1'b1, 16'h0000, 32'h12345678, 0, 0, 32'h0);
    chk("um_wr_strobe", st_str, 0);
    chk("um_wr_ack", ack_n, 1);
    chk("um_wr_cnt", err_unmapped_cnt, 2);

    // stuck waitrequest on channel 0 times out after 8 cycles
    xact(1'b0, 16'h8220, 32'h0, 1000, 1, 32'h0);
    chk("to_strobe_len", str_c[0], 8);
    chk("to_data", rdv_data, 32'hDEADBEEF);
    chk("to_rdv_n", rdv_n, 1);
    chk("to_cnt", err_timeout_cnt, 1);
    xact(1'b1, 16'h8250, 32'h00000077, 0, 0, 32'h0);
    chk("post_to_ch", st_ch, 1);
    chk("post_to_addr", st_addr, 16'h0018);
    chk("post_to_data", st_wdata, 32'h00000077);
    chk("post_to_ack", ack_k, 1);
    chk("post_to_cnt", err_timeout_cnt, 1);

    // window boundaries
    for (int i = 0; i < 7; i++) begin
      logic [31:0] rd;
      rd = 32'hC0DE0000 | 32'(i);
      xact(1'b0, b_addr[i], 32'h0, 0, 1, rd);
      chk($sformatf("bnd%0d_ch", i), st_ch, b_ch[i]);
      if (b_ch[i] >= 0) begin
        chk($sformatf("bnd%0d_addr", i), st_addr, b_off[i]);
        chk($sformatf("bnd%0d_data", i), rdv_data, rd);
      end else begin
        chk($sformatf("bnd%0d_data", i), rdv_data, 32'hDEADBEEF);
      end
    end
    chk("bnd_um_cnt", err_unmapped_cnt, 5);

    // reset while waiting for read data
    @(negedge clk);
    bus.s_address = 16'h8220;
    bus.s_read    = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_read = 1'b0;
    bus.m_readdatavalid = 2'b01;
    bus.m_readdata = {32'h0, 32'h5555AAAA};
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.m_readdatavalid = '0;
      if (bus.s_readdatavalid || !bus.s_waitrequest) seen++;
    end
    chk("mid_no_resp", seen, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_cnts", {err_unmapped_cnt, err_timeout_cnt}, 0);
    chk("mid_wait", bus.s_waitrequest, 1);
    chk("mid_strobes", {bus.m_read, bus.m_write}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
